// File: rtl/i2c_ack_monitor.sv
// Passive observer of an I2C register-init sequence: tracks START/STOP framing,
// checks acks and device address, and reports a pass/fail verdict once init ends.
module i2c_ack_monitor #(
    parameter logic [7:0] DEV_ADDR        = 8'h34,
    parameter int         NUM_FRAMES      = 10,
    parameter int         BYTES_PER_FRAME = 3
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_scl,
    input  logic        i_sda,
    input  logic        i_oen,
    input  logic        i_init_finished,
    output logic        o_nack,
    output logic [3:0]  o_frame_cnt,
    output logic [23:0] o_last_word,
    output logic [2:0]  o_err_code,
    output logic        o_done,
    output logic        o_pass
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BIT,
        S_WAIT_STOP,
        S_DONE
    } state_t;

    localparam logic [3:0] NUM_FRAMES_C = 4'(NUM_FRAMES);
    localparam logic [3:0] LAST_BYTE    = 4'(BYTES_PER_FRAME - 1);

    localparam logic [2:0] ERR_NONE    = 3'd0;
    localparam logic [2:0] ERR_NACK    = 3'd1;
    localparam logic [2:0] ERR_OEN     = 3'd2;
    localparam logic [2:0] ERR_ADDR    = 3'd3;
    localparam logic [2:0] ERR_TRUNC   = 3'd4;
    localparam logic [2:0] ERR_OVFL    = 3'd5;
    localparam logic [2:0] ERR_MISSING = 3'd6;

    state_t      state_reg;
    logic        scl_prev_reg;
    logic        sda_prev_reg;
    logic [3:0]  bit_cnt_reg;
    logic [3:0]  byte_cnt_reg;
    logic [23:0] shift_reg;

    logic        start_det;
    logic        stop_det;
    logic        scl_rise;
    logic        ack_slot;
    logic        nack_next;
    logic [2:0]  raise_code;

    // Bus conditions are only meaningful while SCL is held high across two samples.
    assign start_det = scl_prev_reg & i_scl & sda_prev_reg & ~i_sda;
    assign stop_det  = scl_prev_reg & i_scl & ~sda_prev_reg & i_sda;
    assign scl_rise  = ~scl_prev_reg & i_scl;
    assign ack_slot  = (state_reg == S_BIT) && scl_rise && (bit_cnt_reg == 4'd8);
    assign nack_next = ack_slot && !i_oen && i_sda;

    always_comb begin
        raise_code = ERR_NONE;
        case (state_reg)
            S_IDLE: begin
                if (i_init_finished) begin
                    if (o_frame_cnt < NUM_FRAMES_C)
                        raise_code = ERR_MISSING;
                end else if (start_det && (o_frame_cnt >= NUM_FRAMES_C)) begin
                    raise_code = ERR_OVFL;
                end
            end
            S_BIT: begin
                if (start_det || stop_det) begin
                    raise_code = ERR_TRUNC;
                end else if (ack_slot) begin
                    if (i_oen)
                        raise_code = ERR_OEN;
                    else if (i_sda)
                        raise_code = ERR_NACK;
                    else if ((byte_cnt_reg == 4'd0) && (shift_reg[7:0] != DEV_ADDR))
                        raise_code = ERR_ADDR;
                end
            end
            S_WAIT_STOP: begin
                if (start_det)
                    raise_code = ERR_TRUNC;
            end
            default: raise_code = ERR_NONE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_reg    <= S_IDLE;
            scl_prev_reg <= 1'b1;
            sda_prev_reg <= 1'b1;
            bit_cnt_reg  <= 4'd0;
            byte_cnt_reg <= 4'd0;
            shift_reg    <= 24'd0;
            o_nack       <= 1'b0;
            o_frame_cnt  <= 4'd0;
            o_last_word  <= 24'd0;
            o_err_code   <= ERR_NONE;
            o_done       <= 1'b0;
            o_pass       <= 1'b0;
        end else begin
            scl_prev_reg <= i_scl;
            sda_prev_reg <= i_sda;
            o_nack       <= nack_next;

            // Only the first fault is kept; it is the one worth debugging.
            if ((o_err_code == ERR_NONE) && (raise_code != ERR_NONE))
                o_err_code <= raise_code;

            case (state_reg)
                S_IDLE: begin
                    if (i_init_finished) begin
                        state_reg <= S_DONE;
                        o_done    <= 1'b1;
                        o_pass    <= (o_err_code == ERR_NONE) && (o_frame_cnt == NUM_FRAMES_C);
                    end else if (start_det) begin
                        bit_cnt_reg  <= 4'd0;
                        byte_cnt_reg <= 4'd0;
                        state_reg    <= S_BIT;
                    end
                end
                S_BIT: begin
                    if (start_det) begin
                        bit_cnt_reg  <= 4'd0;
                        byte_cnt_reg <= 4'd0;
                    end else if (stop_det) begin
                        state_reg <= S_IDLE;
                    end else if (scl_rise) begin
                        if (bit_cnt_reg < 4'd8) begin
                            shift_reg   <= {shift_reg[22:0], i_sda};
                            bit_cnt_reg <= bit_cnt_reg + 4'd1;
                        end else begin
                            bit_cnt_reg  <= 4'd0;
                            byte_cnt_reg <= byte_cnt_reg + 4'd1;
                            if (byte_cnt_reg == LAST_BYTE)
                                state_reg <= S_WAIT_STOP;
                        end
                    end
                end
                S_WAIT_STOP: begin
                    if (stop_det) begin
                        o_last_word <= shift_reg;
                        if (o_frame_cnt != 4'hF)
                            o_frame_cnt <= o_frame_cnt + 4'd1;
                        state_reg <= S_IDLE;
                    end else if (start_det) begin
                        bit_cnt_reg  <= 4'd0;
                        byte_cnt_reg <= 4'd0;
                        state_reg    <= S_BIT;
                    end
                end
                S_DONE: begin
                    state_reg <= S_DONE;
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/i2c_ack_monitor.md
I2C_ACK_MONITOR -- requirements
Module: i2c_ack_monitor

Interface
REQ-001 SHALL have parameter DEV_ADDR, default 8'h34: the expected first (address+W) byte of every frame.
REQ-002 SHALL have parameter NUM_FRAMES, default 10: the number of register-write frames expected per init sequence.
REQ-003 SHALL have parameter BYTES_PER_FRAME, default 3: the number of bytes between START and STOP.
REQ-004 i_clk  input  1  the I2C bit clock, shared with the I2C initializer; one clock, no other domain.
REQ-005 i_rst  input  1  reset, synchronous and active-high.
REQ-006 i_scl  input  1  SCL as driven by the initializer.
REQ-007 i_sda  input  1  resolved SDA bus level.
REQ-008 i_oen  input  1  initializer SDA output enable (0 = released for ack).
REQ-009 i_init_finished  input  1  initializer finished flag.
REQ-010 o_nack  output  1  one-cycle pulse on each NACKed byte.
REQ-011 o_frame_cnt  output  4  count of frames completed with a valid STOP.
REQ-012 o_last_word  output  24  the last complete frame's data bits, MSB first, with ack bits excluded.
REQ-013 o_err_code  output  3  first error latched: 0 none, 1 NACK, 2 oen-not-released, 3 bad address, 4 truncated frame, 5 overflow, 6 missing frames.
REQ-014 o_done  output  1  sticky; verdict is valid.
REQ-015 o_pass  output  1  sticky verdict; meaningful only while o_done=1.

Function
REQ-016 All inputs SHALL be treated as synchronous to i_clk, with no synchronizer; previous i_scl/i_sda SHALL be held in one history register each.
REQ-017 START SHALL be defined as previous sda=1, current sda=0 while previous and current scl=1; STOP SHALL be sda 0->1 under the same scl condition; SCL rise SHALL be previous scl=0, current scl=1.
REQ-018 The FSM SHALL have states S_IDLE, S_BIT, S_WAIT_STOP and S_DONE.
REQ-019 S_IDLE: a START SHALL clear bit_cnt and byte_cnt, then go to S_BIT.
REQ-020 S_BIT, on each SCL rise: for bit_cnt 0..7, SHALL shift i_sda into the frame shift register; for bit_cnt 8 (ack slot), SHALL sample the ack; bit_cnt SHALL wrap 8->0 and byte_cnt SHALL increment.
REQ-021 Ack slot: i_oen=1 SHALL cause error 2; otherwise i_sda=1 SHALL cause o_nack to pulse and error 1.
REQ-022 When byte_cnt reaches 0 after byte 0, the byte SHALL be compared to DEV_ADDR; a mismatch SHALL cause error 3.
REQ-023 After ack of byte BYTES_PER_FRAME-1, the FSM SHALL go to S_WAIT_STOP.
REQ-024 S_WAIT_STOP + STOP: o_last_word SHALL load the shift register, o_frame_cnt SHALL increment, and the FSM SHALL go to S_IDLE.
REQ-025 S_WAIT_STOP + START (repeated start) SHALL cause error 4, then the FSM SHALL restart frame collection in S_BIT.
REQ-026 STOP or START seen in S_BIT SHALL cause error 4; STOP SHALL go to S_IDLE and START SHALL restart in S_BIT; o_frame_cnt SHALL be unchanged.
REQ-027 A START in S_IDLE when o_frame_cnt==NUM_FRAMES SHALL cause error 5; the frame SHALL still be tracked; o_frame_cnt SHALL saturate at 15.
REQ-028 In S_IDLE, i_init_finished=1 SHALL cause a go to S_DONE with o_done=1, o_pass=(err==0 && o_frame_cnt==NUM_FRAMES); frame_cnt<NUM_FRAMES with no prior error SHALL latch error 6 and set o_pass=0.
REQ-029 i_init_finished while not in S_IDLE SHALL be ignored until S_IDLE is reached.
REQ-030 S_DONE SHALL be absorbing until reset; bus activity SHALL be ignored.
REQ-031 o_err_code SHALL latch the first nonzero code only; later errors SHALL not overwrite it; o_nack SHALL still pulse for every NACK.
REQ-032 All outputs SHALL be registered; o_nack/o_err_code SHALL update on the clock edge following the SCL-rise cycle (1-cycle latency).
REQ-033 Simultaneous START detection and SCL rise cannot occur (scl stable high); no priority rule SHALL be required beyond REQ-017.

Reset
REQ-034 With i_rst=1 at a clock edge, state SHALL be S_IDLE, history registers=1, and o_nack=0, o_frame_cnt=0, o_last_word=0, o_err_code=0, o_done=0, o_pass=0.
REQ-035 Reset mid-frame SHALL discard the partial frame; monitoring SHALL resume at the next START after deassertion.

Verification
REQ-036 10 well-formed frames 34_00_97…34_12_01 with all acks 0, then i_init_finished -> o_frame_cnt=10, o_last_word=24'h341201, o_done=1, o_pass=1, o_err_code=0.
REQ-037 Frame 3 second-byte ack slot i_sda=1 -> o_nack pulses once, o_err_code=1, final o_pass=0.
REQ-038 First byte 8'h36 on frame 0 -> o_err_code=3; frame still counted on STOP; a later NACK leaves code at 3.
REQ-039 STOP after 17 SCL rises -> o_err_code=4, o_frame_cnt unchanged.
REQ-040 6 good frames then i_init_finished -> o_err_code=6, o_done=1, o_pass=0; an 11th frame in the 10-frame case -> o_err_code=5.
REQ-041 i_rst pulsed mid-byte of frame 2, then 10 good frames -> o_frame_cnt=10, o_pass=1.
